// File: rtl/alu_iter.sv
// alu_iter: ALU with single-cycle integer ops and iterative MUL/DIV.
// Uses a valid/ready handshake on both the request and result sides.
// MUL/DIV run one bit per cycle on operand magnitudes, then fix the sign.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [4:0]      i_alu_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_data,
  output logic            o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_SLT  = 5'h02;
  localparam logic [4:0] OP_SLTU = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_AND  = 5'h06;
  localparam logic [4:0] OP_SLL  = 5'h07;
  localparam logic [4:0] OP_SRL  = 5'h08;
  localparam logic [4:0] OP_SRA  = 5'h09;
  localparam logic [4:0] OP_LUI  = 5'h0A;

  state_t            r_state;
  state_t            w_stateNext;
  logic [SHW-1:0]    r_count;
  logic [2:0]        r_iterOp;
  logic              r_negA;
  logic              r_negB;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_lastIter;
  logic              w_reqIter;
  logic              w_reqDiv;
  logic              w_aSigned;
  logic              w_bSigned;
  logic              w_negA;
  logic              w_negB;
  logic [XLEN-1:0]   w_magA;
  logic [XLEN-1:0]   w_magB;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_aluRes;
  logic [XLEN:0]     w_addend;
  logic [XLEN:0]     w_mulSum;
  logic [XLEN:0]     w_remShift;
  logic [XLEN:0]     w_divDiff;
  logic              w_qBit;
  logic [XLEN-1:0]   w_nextHi;
  logic [XLEN-1:0]   w_nextLo;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prodS;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_iterRes;

  assign o_ready    = i_rst_n && ((r_state == IDLE) || ((r_state == DONE) && i_ready));
  assign o_valid    = (r_state == DONE);
  assign o_busy     = (r_state == EXEC);
  assign o_alu_data = r_result;
  assign w_accept   = i_valid && o_ready;
  assign w_lastIter = (r_count == SHW'(XLEN - 1));

  // Single-cycle ALU result, computed straight from the request inputs
  always_comb begin
    w_shamt  = i_op_b[SHW-1:0];
    w_aluRes = '0;
    case (i_alu_op)
      OP_ADD:  w_aluRes = i_op_a + i_op_b;
      OP_SUB:  w_aluRes = i_op_a - i_op_b;
      OP_SLT:  w_aluRes = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLTU: w_aluRes = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
      OP_XOR:  w_aluRes = i_op_a ^ i_op_b;
      OP_OR:   w_aluRes = i_op_a | i_op_b;
      OP_AND:  w_aluRes = i_op_a & i_op_b;
      OP_SLL:  w_aluRes = i_op_a << w_shamt;
      OP_SRL:  w_aluRes = i_op_a >> w_shamt;
      OP_SRA:  w_aluRes = $unsigned($signed(i_op_a) >>> w_shamt);
      OP_LUI:  w_aluRes = i_op_b;
      default: w_aluRes = '0;
    endcase
  end

  // Request decode: classify the op and reduce signed operands to magnitudes
  always_comb begin
    w_reqIter = (i_alu_op[4:3] == 2'b10);
    w_reqDiv  = i_alu_op[2];
    if (w_reqDiv) begin
      w_aSigned = !i_alu_op[0];
      w_bSigned = !i_alu_op[0];
    end else begin
      w_aSigned = i_alu_op[1] ^ i_alu_op[0];
      w_bSigned = (i_alu_op[1:0] == 2'b01);
    end
    w_negA = w_aSigned && i_op_a[XLEN-1];
    w_negB = w_bSigned && i_op_b[XLEN-1];
    w_magA = w_negA ? -i_op_a : i_op_a;
    w_magB = w_negB ? -i_op_b : i_op_b;
  end

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    w_addend   = r_lo[0] ? {1'b0, r_mcand} : '0;
    w_mulSum   = {1'b0, r_hi} + w_addend;
    w_remShift = {r_hi, r_lo[XLEN-1]};
    w_divDiff  = w_remShift - {1'b0, r_mcand};
    w_qBit     = !w_divDiff[XLEN];
    if (r_iterOp[2]) begin
      w_nextHi = w_qBit ? w_divDiff[XLEN-1:0] : w_remShift[XLEN-1:0];
      w_nextLo = {r_lo[XLEN-2:0], w_qBit};
    end else begin
      w_nextHi = w_mulSum[XLEN:1];
      w_nextLo = {w_mulSum[0], r_lo[XLEN-1:1]};
    end
  end

  // Final MUL/DIV result from the last step, with sign and divide-by-zero fixups
  always_comb begin
    w_prod    = {w_nextHi, w_nextLo};
    w_prodS   = (r_negA ^ r_negB) ? -w_prod : w_prod;
    w_quot    = (r_negA ^ r_negB) ? -w_nextLo : w_nextLo;
    w_rem     = r_negA ? -w_nextHi : w_nextHi;
    w_iterRes = '0;
    case (r_iterOp)
      3'b000:                 w_iterRes = w_prodS[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_iterRes = w_prodS[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_iterRes = (r_mcand == '0) ? '1 : w_quot;
      3'b110, 3'b111:         w_iterRes = w_rem;
      default:                w_iterRes = '0;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  // Next-state logic; a handoff with a new accept behaves like an accept from IDLE
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_accept) w_stateNext = w_reqIter ? EXEC : DONE;
      EXEC: if (w_lastIter) w_stateNext = DONE;
      DONE: begin
        if (w_accept)     w_stateNext = w_reqIter ? EXEC : DONE;
        else if (i_ready) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: capture at accept, iterate in EXEC, result register holds otherwise
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_iterOp <= '0;
      r_negA   <= 1'b0;
      r_negB   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mcand  <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_iterOp <= i_alu_op[2:0];
      r_negA   <= w_negA;
      r_negB   <= w_negB;
      r_hi     <= '0;
      r_lo     <= w_reqDiv ? w_magA : w_magB;
      r_mcand  <= w_reqDiv ? w_magB : w_magA;
      if (!w_reqIter) r_result <= w_aluRes;
    end else if (r_state == EXEC) begin
      r_count <= r_count + 1'b1;
      r_hi    <= w_nextHi;
      r_lo    <= w_nextLo;
      if (w_lastIter) r_result <= w_iterRes;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: self-checking bench for alu_iter at XLEN=32 and XLEN=16.
// Expected results come from an arithmetic reference model of the op table.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rstN;

  logic        valid32, ready32, oValid32, iReady32, busy32;
  logic [31:0] opA32, opB32, data32;
  logic [4:0]  aluOp32;

  logic        valid16, ready16, oValid16, iReady16, busy16;
  logic [15:0] opA16, opB16, data16;
  logic [4:0]  aluOp16;

  int checks   = 0;
  int failures = 0;

  logic [4:0] opList [21] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06,
                              5'h07, 5'h08, 5'h09, 5'h0A, 5'h10, 5'h11, 5'h12,
                              5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h0B, 5'h1F};
  logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

  always #5 clk = ~clk;

  alu_iter #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(valid32), .o_ready(ready32),
    .i_op_a(opA32), .i_op_b(opB32), .i_alu_op(aluOp32), .o_valid(oValid32),
    .i_ready(iReady32), .o_alu_data(data32), .o_busy(busy32)
  );

  alu_iter #(.XLEN(16)) dut16 (
    .i_clk(clk), .i_rst_n(rstN), .i_valid(valid16), .o_ready(ready16),
    .i_op_a(opA16), .i_op_b(opB16), .i_alu_op(aluOp16), .o_valid(oValid16),
    .i_ready(iReady16), .o_alu_data(data16), .o_busy(busy16)
  );

  // Reference model: plain integer arithmetic on width-w values
  function automatic logic [63:0] refAlu(input int w, input logic [4:0] op,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, r;
    longint sa, sb, p;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = ua[w-1] ? longint'(ua | ~mask) : longint'(ua);
    sb = ub[w-1] ? longint'(ub | ~mask) : longint'(ub);
    sh = int'(ub & 64'(w - 1));
    r = 64'd0;
    case (op)
      5'h00: r = ua + ub;
      5'h01: r = ua - ub;
      5'h02: r = (sa < sb) ? 64'd1 : 64'd0;
      5'h03: r = (ua < ub) ? 64'd1 : 64'd0;
      5'h04: r = ua ^ ub;
      5'h05: r = ua | ub;
      5'h06: r = ua & ub;
      5'h07: r = ua << sh;
      5'h08: r = ua >> sh;
      5'h09: r = 64'(sa >>> sh);
      5'h0A: r = ub;
      5'h10: r = ua * ub;
      5'h11: begin p = sa * sb; r = 64'(p >>> w); end
      5'h12: begin p = sa * longint'(ub); r = 64'(p >>> w); end
      5'h13: r = (ua * ub) >> w;
      5'h14: if (ub == 64'd0) r = mask; else r = 64'(sa / sb);
      5'h15: if (ub == 64'd0) r = mask; else r = ua / ub;
      5'h16: if (ub == 64'd0) r = ua; else r = 64'(sa % sb);
      5'h17: if (ub == 64'd0) r = ua; else r = ua % ub;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  // Issue one request on the 32-bit DUT, measure latency and busy cycles, then hand off
  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busyCnt);
    @(negedge clk);
    valid32 = 1'b1; aluOp32 = op; opA32 = a; opB32 = b;
    checks++;
    if (ready32 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready32_before_accept got=%0b want=1", ready32);
    end
    @(posedge clk); #1;
    valid32 = 1'b0; aluOp32 = 5'($urandom); opA32 = $urandom; opB32 = $urandom;
    lat = 1; busyCnt = 0;
    while (oValid32 !== 1'b1 && lat < 100) begin
      if (busy32 === 1'b1) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = data32;
    iReady32 = 1'b1;
    @(posedge clk); #1;
    iReady32 = 1'b0;
  endtask

  task automatic run16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output int lat, output int busyCnt);
    @(negedge clk);
    valid16 = 1'b1; aluOp16 = op; opA16 = a; opB16 = b;
    @(posedge clk); #1;
    valid16 = 1'b0; opA16 = 16'($urandom); opB16 = 16'($urandom);
    lat = 1; busyCnt = 0;
    while (oValid16 !== 1'b1 && lat < 100) begin
      if (busy16 === 1'b1) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = data16;
    iReady16 = 1'b1;
    @(posedge clk); #1;
    iReady16 = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oValid32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%0b want=0", oValid32); end
    checks++; if (busy32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b want=0", busy32); end
    checks++; if (data32 !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h want=0", data32); end
    checks++; if (ready32 !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_low got=%0b want=0", ready32); end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++; if (ready32 !== 1'b1) begin failures++; $display("[TB] FAIL release_ready got=%0b want=1", ready32); end
  endtask

  task automatic test_single_cycle();
    logic [31:0] res; int lat, bc;
    run32(5'h00, 32'h7FFFFFFF, 32'h00000001, res, lat, bc);
    checks++; if (res !== 32'h80000000) begin failures++; $display("[TB] FAIL add_overflow got=%h want=80000000", res); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL add_latency got=%0d want=1", lat); end
    run32(5'h02, 32'hFFFFFFFF, 32'h00000001, res, lat, bc);
    checks++; if (res !== 32'h1) begin failures++; $display("[TB] FAIL slt got=%h want=1", res); end
    run32(5'h03, 32'hFFFFFFFF, 32'h00000001, res, lat, bc);
    checks++; if (res !== 32'h0) begin failures++; $display("[TB] FAIL sltu got=%h want=0", res); end
    run32(5'h0C, 32'h12345678, 32'h9ABCDEF0, res, lat, bc);
    checks++; if (res !== 32'h0) begin failures++; $display("[TB] FAIL illegal_op got=%h want=0", res); end
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat, bc;
    logic [4:0]  ops  [3] = '{5'h10, 5'h13, 5'h11};
    logic [31:0] want [3] = '{32'h00000001, 32'hFFFFFFFE, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      run32(ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, bc);
      checks++; if (res !== want[i]) begin failures++; $display("[TB] FAIL mul_op%h got=%h want=%h", ops[i], res, want[i]); end
      checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL mul_latency_op%h got=%0d want=33", ops[i], lat); end
      checks++; if (bc !== 32) begin failures++; $display("[TB] FAIL mul_busy_op%h got=%0d want=32", ops[i], bc); end
    end
  endtask

  task automatic test_div();
    logic [31:0] res; int lat, bc;
    logic [4:0]  ops  [6] = '{5'h14, 5'h16, 5'h14, 5'h16, 5'h14, 5'h16};
    logic [31:0] aV   [6] = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] bV   [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2};
    logic [31:0] want [6] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'h0, 32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      run32(ops[i], aV[i], bV[i], res, lat, bc);
      checks++; if (res !== want[i]) begin failures++; $display("[TB] FAIL div_case%0d got=%h want=%h", i, res, want[i]); end
      checks++; if (lat !== 33) begin failures++; $display("[TB] FAIL div_latency_case%0d got=%0d want=33", i, lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp; logic [63:0] full; logic [4:0] op; int lat, bc, expLat;
    for (int i = 0; i < 60; i++) begin
      op = opList[$urandom_range(0, 20)];
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      full = refAlu(32, op, {32'h0, a}, {32'h0, b});
      exp = full[31:0];
      expLat = (op >= 5'h10 && op <= 5'h17) ? 33 : 1;
      run32(op, a, b, res, lat, bc);
      checks++; if (res !== exp) begin failures++; $display("[TB] FAIL rand%0d op=%h a=%h b=%h got=%h want=%h", i, op, a, b, res, exp); end
      checks++; if (lat !== expLat) begin failures++; $display("[TB] FAIL rand%0d_latency op=%h got=%0d want=%0d", i, op, lat, expLat); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held; logic [63:0] full; int lat;
    full = refAlu(32, 5'h13, 64'h12345678, 64'h9ABCDEF0);
    @(negedge clk);
    valid32 = 1'b1; aluOp32 = 5'h13; opA32 = 32'h12345678; opB32 = 32'h9ABCDEF0;
    @(posedge clk); #1;
    valid32 = 1'b0;
    lat = 1;
    while (oValid32 !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    held = data32;
    checks++; if (held !== full[31:0]) begin failures++; $display("[TB] FAIL bp_result got=%h want=%h", held, full[31:0]); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (oValid32 !== 1'b1 || data32 !== held || ready32 !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got valid=%0b data=%h ready=%0b want valid=1 data=%h ready=0", i, oValid32, data32, ready32, held);
      end
    end
    @(negedge clk);
    iReady32 = 1'b1; valid32 = 1'b1; aluOp32 = 5'h04; opA32 = 32'hF0F0F0F0; opB32 = 32'hFFFF0000;
    @(posedge clk); #1;
    valid32 = 1'b0;
    checks++;
    if (oValid32 !== 1'b1 || data32 !== 32'h0F0FF0F0) begin
      failures++;
      $display("[TB] FAIL bp_handoff_xor got valid=%0b data=%h want valid=1 data=0f0ff0f0", oValid32, data32);
    end
    @(posedge clk); #1;
    iReady32 = 1'b0;
    checks++; if (oValid32 !== 1'b0) begin failures++; $display("[TB] FAIL bp_return_idle got=%0b want=0", oValid32); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp; logic [63:0] full; logic [4:0] op;
    iReady32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = opList[$urandom_range(0, 10)];
      a = $urandom; b = $urandom;
      full = refAlu(32, op, {32'h0, a}, {32'h0, b});
      exp = full[31:0];
      @(negedge clk);
      valid32 = 1'b1; aluOp32 = op; opA32 = a; opB32 = b;
      @(posedge clk); #1;
      checks++;
      if (oValid32 !== 1'b1 || data32 !== exp) begin
        failures++;
        $display("[TB] FAIL b2b%0d op=%h got valid=%0b data=%h want valid=1 data=%h", i, op, oValid32, data32, exp);
      end
    end
    valid32 = 1'b0;
    @(posedge clk); #1;
    iReady32 = 1'b0;
    checks++; if (oValid32 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain got=%0b want=0", oValid32); end
  endtask

  task automatic test_reset_mid();
    int sawValid;
    @(negedge clk);
    valid32 = 1'b1; aluOp32 = 5'h15; opA32 = $urandom; opB32 = 32'd3;
    @(posedge clk); #1;
    valid32 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (busy32 !== 1'b1) begin failures++; $display("[TB] FAIL divu_busy_before_reset got=%0b want=1", busy32); end
    rstN = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (oValid32 !== 1'b0 || busy32 !== 1'b0 || data32 !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset got valid=%0b busy=%0b data=%h want 0 0 0", oValid32, busy32, data32);
    end
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checks++; if (ready32 !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready got=%0b want=1", ready32); end
    sawValid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (oValid32 !== 1'b0) sawValid++;
    end
    checks++; if (sawValid !== 0) begin failures++; $display("[TB] FAIL midreset_ghost_result got=%0d want=0", sawValid); end
    // A reset while a result waits in DONE must drop it
    @(negedge clk);
    valid32 = 1'b1; aluOp32 = 5'h00; opA32 = 32'd5; opB32 = 32'd6;
    @(posedge clk); #1;
    valid32 = 1'b0;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (oValid32 !== 1'b0) begin failures++; $display("[TB] FAIL done_reset got=%0b want=0", oValid32); end
  endtask

  task automatic test_xlen16();
    logic [15:0] res, a, b; logic [63:0] full; logic [4:0] op; int lat, bc;
    run16(5'h09, 16'h8000, 16'd15, res, lat, bc);
    checks++; if (res !== 16'hFFFF) begin failures++; $display("[TB] FAIL x16_sra got=%h want=ffff", res); end
    run16(5'h07, 16'h0001, 16'h0013, res, lat, bc);
    checks++; if (res !== 16'h0008) begin failures++; $display("[TB] FAIL x16_sll got=%h want=0008", res); end
    run16(5'h13, 16'hFFFF, 16'hFFFF, res, lat, bc);
    checks++; if (res !== 16'hFFFE) begin failures++; $display("[TB] FAIL x16_mulhu got=%h want=fffe", res); end
    checks++; if (lat !== 17) begin failures++; $display("[TB] FAIL x16_mulhu_latency got=%0d want=17", lat); end
    checks++; if (bc !== 16) begin failures++; $display("[TB] FAIL x16_mulhu_busy got=%0d want=16", bc); end
    for (int i = 0; i < 20; i++) begin
      op = opList[$urandom_range(0, 20)];
      a = 16'($urandom); b = 16'($urandom);
      full = refAlu(16, op, {48'h0, a}, {48'h0, b});
      run16(op, a, b, res, lat, bc);
      checks++; if (res !== full[15:0]) begin failures++; $display("[TB] FAIL x16_rand%0d op=%h a=%h b=%h got=%h want=%h", i, op, a, b, res, full[15:0]); end
    end
  endtask

  // Top-level sequence
  initial begin
    rstN = 1'b0;
    valid32 = 1'b0; iReady32 = 1'b0; opA32 = '0; opB32 = '0; aluOp32 = '0;
    valid16 = 1'b0; iReady16 = 1'b0; opA16 = '0; opB16 = '0; aluOp16 = '0;
    test_reset();
    test_single_cycle();
    test_mul();
    test_div();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_xlen16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog_timeout got=expired want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 16, 32, 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width; not overridden independently.
REQ-003 SHALL have one clock and a synchronous, active-low reset, with ports as follows.
REQ-004 i_clk  input  1  clock, all state updates on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_valid  input  1  request valid.
REQ-007 o_ready  output  1  block can accept a request this cycle.
REQ-008 i_op_a  input  XLEN  operand A.
REQ-009 i_op_b  input  XLEN  operand B (immediate for LUI).
REQ-010 i_alu_op  input  5  operation code.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  consumer accepts result this cycle.
REQ-013 o_alu_data  output  XLEN  result.
REQ-014 o_busy  output  1  high while an iterative MUL/DIV op is executing.

Function
REQ-015 Opcodes SHALL be: 0x00 ADD, 0x01 SUB, 0x02 SLT, 0x03 SLTU, 0x04 XOR, 0x05 OR, 0x06 AND, 0x07 SLL, 0x08 SRL, 0x09 SRA, 0x0A LUI (result = i_op_b), 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU; any other code SHALL produce result 0 on the single-cycle path.
REQ-016 Opcodes 0x00-0x0A SHALL have the same semantics and encodings as the existing single-cycle ALU, generalised to XLEN; shift amount = i_op_b[SHW-1:0].
REQ-017 Accept SHALL occur on a rising edge with i_valid && o_ready; operands and opcode SHALL be captured only at accept.
REQ-018 FSM states SHALL be IDLE, EXEC, DONE.
REQ-019 IDLE: o_ready=1; accept of a single-cycle op SHALL register the result and go to DONE; accept of an op in 0x10-0x17 SHALL go to EXEC with iteration counter cleared.
REQ-020 EXEC: o_busy=1, o_ready=0; radix-2 shift-add multiply or restoring divide, one bit per cycle, exactly XLEN cycles, then DONE.
REQ-021 Latency: o_valid SHALL rise 1 cycle after accept for single-cycle ops and XLEN+1 cycles after accept for MUL/DIV ops (33 for XLEN=32), independent of operand values.
REQ-022 DONE: o_valid=1; o_alu_data and o_valid SHALL hold stable until i_ready=1.
REQ-023 In DONE, o_ready SHALL equal i_ready; a simultaneous result handoff and new accept SHALL be handled like an accept from IDLE (back-to-back, no bubble); a handoff without new accept SHALL return to IDLE.
REQ-024 i_valid while o_ready=0 SHALL be ignored; the requester holds it.
REQ-025 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of signed x signed, signed x unsigned, unsigned x unsigned products.
REQ-026 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
REQ-027 Signed overflow (most-negative / -1): DIV = most-negative, REM = 0.
REQ-028 DIV/REM quotient truncates toward zero; remainder takes sign of dividend.
REQ-029 In IDLE and EXEC, o_valid SHALL be 0 and o_alu_data SHALL hold its last value.

Reset
REQ-030 On a rising edge with i_rst_n=0: state=IDLE, o_valid=0, o_busy=0, o_alu_data=0, iteration counter and internal accumulators=0.
REQ-031 o_ready SHALL be 0 while i_rst_n=0 and 1 in the first cycle after release.
REQ-032 Reset mid-EXEC or in DONE SHALL discard the operation; no result SHALL appear after release.

Verification
REQ-033 XLEN=32: ADD 0x7FFFFFFF+0x00000001 -> o_valid 1 cycle after accept, 0x80000000; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-034 XLEN=32: MUL, MULHU, MULH, each 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001, 0xFFFFFFFE, 0x00000000; o_valid exactly 33 cycles after each accept; o_busy high 32 cycles.
REQ-035 XLEN=32: DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
REQ-036 Backpressure: result in DONE, i_ready=0 for 5 cycles -> o_valid=1, o_alu_data stable, o_ready=0; then i_ready=1 with i_valid=1 (XOR 0xF0F0F0F0,0xFFFF0000) -> next cycle o_valid=1, 0x0F0FF0F0.
REQ-037 Reset: i_rst_n=0 on cycle 10 of DIVU -> next cycle o_valid=0, o_busy=0, o_alu_data=0; after release o_ready=1 and o_valid stays 0 until a new accept.
REQ-038 XLEN=16: SRA 0x8000 by 15 -> 0xFFFF; SLL 0x0001 by 0x0013 (shift amount 3) -> 0x0008; MULHU 0xFFFF x 0xFFFF -> 0xFFFE after 17 cycles.
